// File: rtl/bp_pkg.sv
// Shared types for the branch-history-table update path: FSM encoding and
// the layout of one queued update.
package bp_pkg;

    localparam int unsigned BP_IDX_W = 5;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_INIT  = 2'd1,
        S_RUN   = 2'd2
    } bp_state_e;

    // Queued resolved-branch update; idx width must match the top's IDX_W.
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } upd_entry_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Small FIFO of pending BHT updates. Head is visible combinationally so the
// scheduler can compare it against the fetch lookup in the same cycle.
module bht_upd_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  upd_entry_t i_entry,
    input  logic       i_pop,
    output upd_entry_t o_head_c,
    output logic       o_full_c,
    output logic       o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    upd_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_c  = r_mem[r_rptr];
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/bht_update_scheduler.sv
// Schedules writes into the 2-bit-counter BHT: sweeps the table to
// weakly-not-taken after reset/clear, then drains queued updates while
// dodging same-index fetch lookups for a bounded number of cycles.
module bht_update_scheduler
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W     = BP_IDX_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_DEFER = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clear,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             bht_we,
    output logic [IDX_W-1:0] bht_waddr,
    output logic             bht_taken,
    output logic             bht_init,
    output logic             busy
);

    localparam int unsigned N_ENT = 1 << IDX_W;
    localparam int unsigned DEF_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

    bp_state_e        r_state;
    bp_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_init_cnt;
    logic [DEF_W-1:0] r_defer;

    upd_entry_t w_entry;
    upd_entry_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;
    logic       w_hold;
    logic       w_conflict;

    assign w_entry    = '{idx: upd_idx, taken: upd_taken};
    assign w_conflict = lk_valid && (lk_idx == w_head.idx);

    bht_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_flush   (w_flush),
        .i_push    (w_push),
        .i_entry   (w_entry),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write-port arbitration; bht_* see only registered state, clear and lk_*.
    always_comb begin
        w_state_nxt = r_state;
        upd_ready   = 1'b0;
        busy        = 1'b1;
        bht_we      = 1'b0;
        bht_waddr   = '0;
        bht_taken   = 1'b0;
        bht_init    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_hold      = 1'b0;
        unique case (r_state)
            S_START: begin
                w_state_nxt = S_INIT;
            end
            S_INIT: begin
                bht_we    = 1'b1;
                bht_init  = 1'b1;
                bht_waddr = r_init_cnt;
                if (r_init_cnt == IDX_W'(N_ENT - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b0;
                if (clear) begin
                    // The table is about to be re-swept, so drop the head too.
                    w_flush     = 1'b1;
                    w_state_nxt = S_INIT;
                end else begin
                    upd_ready = !w_full;
                    w_push    = upd_valid && !w_full;
                    if (!w_empty) begin
                        if (!w_conflict || (r_defer == DEF_W'(MAX_DEFER))) begin
                            w_pop     = 1'b1;
                            bht_we    = 1'b1;
                            bht_waddr = w_head.idx;
                            bht_taken = w_head.taken;
                        end else begin
                            w_hold = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_init_cnt <= '0;
            r_defer    <= '0;
        end else begin
            if (w_flush) begin
                r_init_cnt <= '0;
            end else if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt + IDX_W'(1);
            end
            if (w_flush || w_pop) begin
                r_defer <= '0;
            end else if (w_hold) begin
                r_defer <= r_defer + DEF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Scoreboard bench for bht_update_scheduler: a cycle-level reference model
// predicts handshake/init behaviour, a monitor checks every update write.
module tb_bht_update_scheduler;

    localparam int IDX_W     = 5;
    localparam int DEPTH     = 4;
    localparam int MAX_DEFER = 2;
    localparam int N         = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             clear;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             bht_we;
    logic [IDX_W-1:0] bht_waddr;
    logic             bht_taken;
    logic             bht_init;
    logic             busy;

    always #5 clk = ~clk;

    bht_update_scheduler #(
        .IDX_W     (IDX_W),
        .DEPTH     (DEPTH),
        .MAX_DEFER (MAX_DEFER)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .clear     (clear),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken),
        .lk_valid  (lk_valid),
        .lk_idx    (lk_idx),
        .bht_we    (bht_we),
        .bht_waddr (bht_waddr),
        .bht_taken (bht_taken),
        .bht_init  (bht_init),
        .busy      (busy)
    );

    typedef struct {
        int idx;
        int taken;
    } ent_t;

    ent_t m_q[$];
    ent_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_phase = 0;   // 0 = starting, 1 = sweeping table, 2 = running
    int   m_init = 0;
    int   m_defer = 0;
    bit   m_acc;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Predict this cycle's outputs, compare, then advance the model over the edge.
    task automatic model_cycle();
        bit e_we = 0, e_init = 0, e_busy, e_ready = 0, e_issue = 0, e_conf;
        int e_addr = 0;
        if (!arst_n) begin
            m_phase = 0; m_init = 0; m_defer = 0;
            m_q.delete(); sb_q.delete();
        end
        e_busy = (m_phase != 2);
        if (m_phase == 1) begin
            e_we = 1; e_init = 1; e_addr = m_init;
        end
        if (m_phase == 2 && !clear) begin
            e_ready = (m_q.size() < DEPTH);
            if (m_q.size() > 0) begin
                e_conf = lk_valid && (int'(lk_idx) == m_q[0].idx);
                if (!e_conf || m_defer >= MAX_DEFER) begin
                    e_issue = 1; e_we = 1;
                end
            end
        end
        chk("upd_ready", int'(upd_ready), int'(e_ready));
        chk("busy", int'(busy), int'(e_busy));
        chk("bht_we", int'(bht_we), int'(e_we));
        chk("bht_init", int'(bht_init), int'(e_init));
        if (e_init) chk("init_waddr", int'(bht_waddr), e_addr);
        if (m_phase == 0) begin
            chk("idle_waddr", int'(bht_waddr), 0);
            chk("idle_taken", int'(bht_taken), 0);
        end
        m_acc = upd_valid && e_ready;
        if (!arst_n) return;
        case (m_phase)
            0: begin m_phase = 1; m_init = 0; end
            1: begin
                if (m_init == N - 1) m_phase = 2;
                m_init = (m_init + 1) % N;
            end
            default: begin
                if (clear) begin
                    m_q.delete(); sb_q.delete();
                    m_defer = 0; m_init = 0; m_phase = 1;
                end else begin
                    if (e_issue) begin
                        void'(m_q.pop_front());
                        m_defer = 0;
                    end else if (m_q.size() > 0) begin
                        m_defer++;
                    end
                    if (m_acc) begin
                        ent_t e;
                        e.idx = int'(upd_idx); e.taken = int'(upd_taken);
                        m_q.push_back(e); sb_q.push_back(e);
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit rst, input bit clr, input bit uv, input int ui,
                        input bit ut, input bit lv, input int li);
        @(negedge clk);
        arst_n    = rst;
        clear     = clr;
        upd_valid = uv;
        upd_idx   = IDX_W'(ui);
        upd_taken = ut;
        lk_valid  = lv;
        lk_idx    = IDX_W'(li);
        #1 model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every non-init table write must match the oldest accepted update.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (arst_n && bht_we && !bht_init) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    ent_t e;
                    e = sb_q.pop_front();
                    chk("wr_idx", int'(bht_waddr), e.idx);
                    chk("wr_taken", int'(bht_taken), e.taken);
                end
            end
        end
    end

    initial begin
        int n_acc;
        arst_n = 0; clear = 0; upd_valid = 0; upd_idx = '0;
        upd_taken = 0; lk_valid = 0; lk_idx = '0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        idle(1 + N + 2);

        // Lone update, no lookup traffic.
        step(1, 0, 1, 7, 1, 0, 0);
        idle(3);

        // Lookup parked on the head index: two deferrals then a forced write.
        step(1, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 3);

        // Back-to-back offers against a conflicting lookup.
        n_acc = 0;
        for (int i = 0; i < 20 && n_acc < 5; i++) begin
            step(1, 0, 1, 9 + n_acc, n_acc % 2, 1, m_q.size() ? m_q[0].idx : 9);
            if (m_acc) n_acc++;
        end
        chk("burst_accepts", n_acc, 5);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, m_q.size() ? m_q[0].idx : 0);

        // Three queued entries then clear: re-sweep, nothing from the queue written.
        step(1, 0, 1, 20, 1, 1, 20);
        step(1, 0, 1, 21, 1, 1, 20);
        step(1, 0, 1, 22, 0, 1, 20);
        chk("queued_before_clear", m_q.size(), 3);
        step(1, 1, 1, 23, 1, 1, 20);
        idle(N + 2);

        // Reset pulse in the middle of the sweep.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3 * N && !(m_phase == 1 && m_init == 17); i++) idle(1);
        chk("reached_init17", m_init, 17);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(N + 3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rst, clr, uv, ut, lv;
            int ui, li;
            rst = ($urandom_range(0, 399) != 0);
            clr = ($urandom_range(0, 79) == 0);
            uv  = ($urandom_range(0, 2) != 0);
            ui  = $urandom_range(0, N - 1);
            ut  = 1'($urandom_range(0, 1));
            lv  = ($urandom_range(0, 1) != 0);
            li  = (m_q.size() > 0 && $urandom_range(0, 1) != 0) ? m_q[0].idx
                                                              : $urandom_range(0, N - 1);
            step(rst, clr, uv, ui, ut, lv, li);
        end

        // Drain whatever is left, bounded.
        for (int i = 0; i < 3 * N && (m_phase != 2 || m_q.size() > 0); i++) idle(1);
        idle(2);
        chk("drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
